// File: rtl/mema_pkg.sv
// mema_pkg: shared FSM state type, lane slice width and default parameters
// for the memA read scheduler.
package mema_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_e;

    localparam int LANE_W     = 32;
    localparam int DEF_LANES  = 4;
    localparam int DEF_UNITS  = 8;
    localparam int DEF_ADDR_W = 32;

endpackage

// File: rtl/mema_lane_ctrl.sv
// mema_lane_ctrl: per-lane valid flag and 1-based chunk index derived from
// the shared beat counter and this lane's (already non-zero) multiple.
module mema_lane_ctrl
    import mema_pkg::*;
(
    input  logic              active_i,
    input  logic [LANE_W-1:0] k_i,
    input  logic [LANE_W-1:0] mult_i,
    output logic              valid_o,
    output logic [LANE_W-1:0] index_o
);

    always_comb begin
        valid_o = active_i && (k_i <= mult_i);
        index_o = !active_i ? LANE_W'(1) : (k_i < mult_i) ? k_i : mult_i;
    end

endmodule

// File: rtl/mema_read_scheduler.sv
// mema_read_scheduler: walks memA words from a latched base, presenting
// per-lane chunks beat by beat with all-lane ready backpressure.
module mema_read_scheduler
    import mema_pkg::*;
#(
    parameter int NO_OF_ROW_BY_VECTOR_MODULES = DEF_LANES,
    parameter int NO_OF_UNITS                 = DEF_UNITS,
    parameter int ADDR_WIDTH                  = DEF_ADDR_W
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic [ADDR_WIDTH-1:0]                         base_address,
    input  logic [31:0]                                   no_of_row_groups,
    input  logic [LANE_W*NO_OF_ROW_BY_VECTOR_MODULES-1:0] no_of_multiples,
    input  logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0]        I_am_ready,
    output logic [ADDR_WIDTH-1:0]                         memA_read_address,
    output logic [LANE_W*NO_OF_ROW_BY_VECTOR_MODULES-1:0] chunk_index,
    output logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0]        lane_valid,
    output logic                                          busy,
    output logic                                          done
);

    localparam int N = NO_OF_ROW_BY_VECTOR_MODULES;

    if (NO_OF_UNITS < 1) begin : g_bad_units
        $error("NO_OF_UNITS must be at least 1");
    end

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           rows_q, rows_d;
    logic [31:0]           word_q, word_d;
    logic [LANE_W-1:0]     k_q, k_d;
    logic [LANE_W-1:0]     max_q, max_d;
    logic [LANE_W*N-1:0]   mult_q, mult_d;
    logic [LANE_W*N-1:0]   start_mult;
    logic [LANE_W-1:0]     start_max;
    logic                  active;
    logic                  beat_done;

    // Zero multiples are promoted to 1 at latch time so every lane sees at least one chunk.
    always_comb begin
        start_mult = '0;
        start_max  = LANE_W'(1);
        for (int l = 0; l < N; l++) begin
            start_mult[LANE_W*l +: LANE_W] = (no_of_multiples[LANE_W*l +: LANE_W] == '0) ?
                LANE_W'(1) : no_of_multiples[LANE_W*l +: LANE_W];
            if (start_mult[LANE_W*l +: LANE_W] > start_max)
                start_max = start_mult[LANE_W*l +: LANE_W];
        end
    end

    assign active    = (state_q == ISSUE);
    assign beat_done = active && (&(I_am_ready | ~lane_valid));

    for (genvar l = 0; l < N; l++) begin : g_lane
        mema_lane_ctrl u_lane (
            .active_i (active),
            .k_i      (k_q),
            .mult_i   (mult_q[LANE_W*l +: LANE_W]),
            .valid_o  (lane_valid[l]),
            .index_o  (chunk_index[LANE_W*l +: LANE_W])
        );
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rows_d  = rows_q;
        word_d  = word_q;
        k_d     = k_q;
        max_d   = max_q;
        mult_d  = mult_q;
        case (state_q)
            IDLE: if (start) begin
                addr_d  = base_address;
                rows_d  = no_of_row_groups;
                mult_d  = start_mult;
                max_d   = start_max;
                k_d     = LANE_W'(1);
                word_d  = 32'd1;
                state_d = (no_of_row_groups == '0) ? FINISH : ISSUE;
            end
            ISSUE: if (beat_done) begin
                if (k_q == max_q) begin
                    k_d    = LANE_W'(1);
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    // Word counter stops at rows_q, so it never wraps even for 2^32-1 words.
                    if (word_q == rows_q) state_d = FINISH;
                    else word_d = word_q + 32'd1;
                end else begin
                    k_d = k_q + LANE_W'(1);
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rows_q  <= '0;
            word_q  <= 32'd1;
            k_q     <= LANE_W'(1);
            max_q   <= LANE_W'(1);
            mult_q  <= {N{LANE_W'(1)}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rows_q  <= rows_d;
            word_q  <= word_d;
            k_q     <= k_d;
            max_q   <= max_d;
            mult_q  <= mult_d;
        end
    end

    assign memA_read_address = addr_q;
    assign busy              = (state_q == ISSUE);
    assign done              = (state_q == FINISH);

endmodule

// File: tb/tb_mema_read_scheduler.sv
// tb_mema_read_scheduler: scenario tasks driving the scheduler and scoring
// every cycle against a beat list built from the chunking rules.
module tb_mema_read_scheduler;

    localparam int N  = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic [31:0]   no_of_row_groups = '0;
    logic [127:0]  no_of_multiples = '0;
    logic [N-1:0]  I_am_ready = '0;
    logic [AW-1:0] memA_read_address;
    logic [127:0]  chunk_index;
    logic [N-1:0]  lane_valid;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [3:0]   valid;
        logic [127:0] idx;
    } beat_t;

    beat_t exp_q[$];

    mema_read_scheduler #(
        .NO_OF_ROW_BY_VECTOR_MODULES(N),
        .NO_OF_UNITS(8),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_address(base_address),
        .no_of_row_groups(no_of_row_groups),
        .no_of_multiples(no_of_multiples),
        .I_am_ready(I_am_ready),
        .memA_read_address(memA_read_address),
        .chunk_index(chunk_index),
        .lane_valid(lane_valid),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Expected beat list: every word repeats max(multiple) beats; a lane is live while k <= its multiple.
    task automatic build_model(input logic [31:0] base, input logic [31:0] rows, input logic [127:0] mults);
        int m[4];
        int mx;
        exp_q.delete();
        mx = 1;
        for (int l = 0; l < 4; l++) begin
            m[l] = int'(mults[32*l +: 32]);
            if (m[l] == 0) m[l] = 1;
            if (m[l] > mx) mx = m[l];
        end
        for (int w = 0; w < int'(rows); w++)
            for (int k = 1; k <= mx; k++) begin
                beat_t b;
                b.addr = base + 32'(w);
                for (int l = 0; l < 4; l++) begin
                    b.valid[l] = (k <= m[l]);
                    b.idx[32*l +: 32] = 32'((k < m[l]) ? k : m[l]);
                end
                exp_q.push_back(b);
            end
    endtask

    // mode 0: always ready; 1: random ready plus stray starts; 2: lane 2 not ready for 3 cycles in beat 2.
    task automatic run_pass(input logic [31:0] base, input logic [31:0] rows, input logic [127:0] mults,
                            input int mode, output int done_at, output int stalls);
        int bi;
        int st_left;
        logic [3:0] rdy;
        build_model(base, rows, mults);
        base_address = base;
        no_of_row_groups = rows;
        no_of_multiples = mults;
        I_am_ready = 4'hF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bi = 0;
        done_at = -1;
        stalls = 0;
        st_left = 3;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (bi < exp_q.size()) begin
                beat_t b;
                b = exp_q[bi];
                checks++;
                if ({memA_read_address, lane_valid, chunk_index, busy, done} !== {b.addr, b.valid, b.idx, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL beat%0d cyc%0d got addr=%h valid=%b idx=%h busy=%b done=%b want addr=%h valid=%b idx=%h busy=1 done=0",
                             bi, cyc, memA_read_address, lane_valid, chunk_index, busy, done, b.addr, b.valid, b.idx);
                end
                rdy = 4'hF;
                if (mode == 1) begin
                    rdy = 4'($urandom);
                    start = ($urandom_range(0, 3) == 0);
                    base_address = $urandom;
                    no_of_row_groups = $urandom_range(0, 9);
                    no_of_multiples = {$urandom, $urandom, $urandom, $urandom};
                end else if (mode == 2 && bi == 1 && st_left > 0) begin
                    rdy = 4'b1011;
                    st_left--;
                end
                I_am_ready = rdy;
                if (&(rdy | ~b.valid)) bi++;
                else stalls++;
            end else begin
                checks++;
                if ({lane_valid, chunk_index, busy, done} !== {4'b0000, {4{32'd1}}, 1'b0, 1'b1}) begin
                    failures++;
                    $display("FAIL finish cyc%0d got valid=%b idx=%h busy=%b done=%b want valid=0000 idx=all1 busy=0 done=1",
                             cyc, lane_valid, chunk_index, busy, done);
                end
                done_at = cyc;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                checks++;
                if ({busy, done, lane_valid} !== 6'b0) begin
                    failures++;
                    $display("FAIL start_in_finish got busy=%b done=%b valid=%b want all 0", busy, done, lane_valid);
                end
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        I_am_ready = 4'hF;
        if (done_at < 0) begin
            failures++;
            $display("FAIL timeout got no done within 300 cycles want done");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({memA_read_address, lane_valid, chunk_index, busy, done} !== {32'd0, 4'b0, {4{32'd1}}, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset got addr=%h valid=%b idx=%h busy=%b done=%b want addr=0 valid=0 idx=all1 busy=0 done=0",
                     memA_read_address, lane_valid, chunk_index, busy, done);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int d, s;
        run_pass(32'h10, 32'd2, {32'd4, 32'd3, 32'd2, 32'd1}, 0, d, s);
        checks++;
        if (d != 9) begin
            failures++;
            $display("FAIL basic_done_delay got %0d want 9", d);
        end
    endtask

    task automatic test_stall();
        int d, s;
        run_pass(32'h10, 32'd2, {32'd4, 32'd3, 32'd2, 32'd1}, 2, d, s);
        checks++;
        if (d != 12 || s != 3) begin
            failures++;
            $display("FAIL stall_done_delay got done=%0d stalls=%0d want done=12 stalls=3", d, s);
        end
    endtask

    task automatic test_zero_rows();
        int d, s;
        run_pass(32'h40, 32'd0, {32'd2, 32'd2, 32'd2, 32'd2}, 0, d, s);
        checks++;
        if (d != 1) begin
            failures++;
            $display("FAIL zero_rows_done got %0d want 1", d);
        end
    endtask

    task automatic test_zero_mult();
        int d, s;
        run_pass(32'h200, 32'd3, 128'd0, 0, d, s);
        checks++;
        if (d != 4) begin
            failures++;
            $display("FAIL zero_mult_done got %0d want 4", d);
        end
    endtask

    task automatic test_reset_mid();
        int d, s;
        logic seen_done;
        base_address = 32'h10;
        no_of_row_groups = 32'd2;
        no_of_multiples = {32'd4, 32'd3, 32'd2, 32'd1};
        I_am_ready = 4'hF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if ({lane_valid, chunk_index[127:96]} !== {4'b1100, 32'd3}) begin
            failures++;
            $display("FAIL reset_mid_beat3 got valid=%b idx3=%0d want valid=1100 idx3=3", lane_valid, chunk_index[127:96]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({memA_read_address, lane_valid, chunk_index, busy, done} !== {32'd0, 4'b0, {4{32'd1}}, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid got addr=%h valid=%b idx=%h busy=%b done=%b want reset values",
                     memA_read_address, lane_valid, chunk_index, busy, done);
        end
        seen_done = 1'b0;
        repeat (3) begin @(posedge clk); #1; seen_done |= done; end
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; seen_done |= done; end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_done got done=1 want 0");
        end
        run_pass(32'h10, 32'd2, {32'd4, 32'd3, 32'd2, 32'd1}, 0, d, s);
        checks++;
        if (d != 9) begin
            failures++;
            $display("FAIL reset_mid_restart got %0d want 9", d);
        end
    endtask

    task automatic test_wrap();
        int d, s;
        run_pass(32'hFFFF_FFFF, 32'd2, {32'd1, 32'd1, 32'd1, 32'd1}, 0, d, s);
        checks++;
        if (d != 3) begin
            failures++;
            $display("FAIL wrap_done got %0d want 3", d);
        end
    endtask

    task automatic test_random();
        int d, s;
        for (int t = 0; t < 8; t++) begin
            logic [127:0] m;
            logic [31:0] rows;
            for (int l = 0; l < 4; l++) m[32*l +: 32] = $urandom_range(0, 5);
            rows = $urandom_range(1, 4);
            run_pass($urandom, rows, m, 1, d, s);
            checks++;
            if (d != exp_q.size() + s + 1) begin
                failures++;
                $display("FAIL random%0d_done got %0d want %0d", t, d, exp_q.size() + s + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_rows();
        test_zero_mult();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
